// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: size encodings,
// response FSM states and a helper that decodes a transfer size.
package mem_pkg;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  // Number of bytes moved by a one-hot size code; 0 marks an illegal code.
  function automatic logic [3:0] size_bytes(input logic [3:0] req_size);
    case (req_size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      SZ_D:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_ctrl.sv
// Byte-lane helper for the data-memory responder: turns a size code into a
// byte-enable mask, flags misaligned addresses and zero-extends read data.
module mem_lane_ctrl
  import mem_pkg::*;
(
  input  logic [3:0]  req_size,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] raw_rdata,
  output logic [7:0]  byte_en,
  output logic        misaligned,
  output logic [63:0] ext_rdata
);

  // Select the active byte lanes and check natural alignment for the size
  always_comb begin
    byte_en    = 8'h00;
    misaligned = 1'b0;
    case (req_size)
      SZ_B: begin
        byte_en = 8'h01;
      end
      SZ_H: begin
        byte_en    = 8'h03;
        misaligned = addr_lo[0];
      end
      SZ_W: begin
        byte_en    = 8'h0F;
        misaligned = |addr_lo[1:0];
      end
      SZ_D: begin
        byte_en    = 8'hFF;
        misaligned = |addr_lo;
      end
      default: begin
        byte_en    = 8'h00;
        misaligned = 1'b0;
      end
    endcase
  end

  // Clear every byte lane beyond the transfer size so loads are zero-extended
  always_comb begin
    ext_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      if (byte_en[k]) begin
        ext_rdata[8*k +: 8] = raw_rdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/datamem_responder.sv
// Responder end of the MEM-stage data-memory interface. Services one
// load/store at a time from a byte-addressed array and answers after a
// fixed latency so the pipeline's stall logic sees real memory delay.
module datamem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept;
  logic        req_err;
  logic        misaligned;
  logic [7:0]  byte_en;
  logic [3:0]  nbytes;
  logic [64:0] end_addr;
  logic [AW-1:0] base;
  logic [63:0] raw_rdata;
  logic [63:0] ext_rdata;

  mem_lane_ctrl u_lane (
    .req_size   (req_size),
    .addr_lo    (req_addr[2:0]),
    .raw_rdata  (raw_rdata),
    .byte_en    (byte_en),
    .misaligned (misaligned),
    .ext_rdata  (ext_rdata)
  );

  // The end address uses an extra bit so requests near 2^64 cannot wrap
  // back into range and slip past the bounds check.
  assign nbytes     = size_bytes(req_size);
  assign end_addr   = {1'b0, req_addr} + {61'd0, nbytes};
  assign req_err    = (nbytes == 4'd0) || misaligned ||
                      (end_addr > 65'(DEPTH_BYTES));
  assign base       = req_addr[AW-1:0];

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Gather eight consecutive bytes from the request address; lanes past the
  // transfer size are discarded by the lane helper.
  always_comb begin
    raw_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      raw_rdata[8*k +: 8] = mem[base + AW'(k)];
    end
  end

  // Next-state and latency-counter logic for the single outstanding request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and counter registers; reset abandons any pending response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the response at acceptance and clear it once it is consumed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= req_err;
      rdata_q <= (req_err || req_write) ? 64'd0 : ext_rdata;
    end else if (resp_valid && resp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  // Stores commit at the acceptance edge so a following load sees them;
  // the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      for (int k = 0; k < 8; k++) begin
        if (byte_en[k]) begin
          mem[base + AW'(k)] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_datamem_responder.sv
// Self-checking bench for datamem_responder: directed cases plus random
// loads/stores compared against a byte-array reference model.
module tb_datamem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int nChecks = 0;
  int nFail   = 0;

  logic [7:0] refMem [DEPTH];

  datamem_responder #(
    .DEPTH_BYTES (DEPTH),
    .LATENCY     (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies the size/alignment/bounds rules and the
  // little-endian byte layout directly on a byte array.
  task automatic modelTxn(input logic write, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [3:0] size,
                          output logic err, output logic [63:0] data);
    int n;
    case (size)
      4'b0001: n = 1;
      4'b0010: n = 2;
      4'b0100: n = 4;
      4'b1000: n = 8;
      default: n = 0;
    endcase
    err = 1'b0;
    if (n == 0) err = 1'b1;
    else if ((addr % 64'(n)) != 64'd0) err = 1'b1;
    else if (({1'b0, addr} + 65'(n)) > 65'(DEPTH)) err = 1'b1;
    data = 64'd0;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        if (write) refMem[int'(addr) + k] = wdata[8*k +: 8];
        else data = data | (64'(refMem[int'(addr) + k]) << (8 * k));
      end
    end
  endtask

  // One full transaction: request, latency, response, optional back-pressure
  task automatic applyStimulus(input logic write, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [3:0] size,
                               input int hold, output logic [63:0] gotData,
                               output logic gotErr);
    logic        expErr;
    logic [63:0] expData;
    int          cycles;
    modelTxn(write, addr, wdata, size, expErr, expData);
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    checkOutput("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_size  = 4'($urandom);
    req_write = 1'($urandom);
    checkOutput("req_ready_busy", 64'(req_ready), 64'd0);
    cycles = 0;
    while (!resp_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("latency", 64'(cycles), 64'(LATENCY));
    checkOutput("rdata", resp_rdata, expData);
    checkOutput("err", 64'(resp_err), 64'(expErr));
    gotData = resp_rdata;
    gotErr  = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 64'(resp_valid), 64'd1);
      checkOutput("hold_rdata", resp_rdata, expData);
      checkOutput("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkOutput("done_valid", 64'(resp_valid), 64'd0);
    checkOutput("done_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] d;
    logic        e;
    logic        w;
    logic [3:0]  sz;
    logic [63:0] a;
    int          n;
    int          sel;

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_size   = 4'b0001;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_rdata", resp_rdata, 64'd0);
    checkOutput("rst_err", 64'(resp_err), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] filling low region and top of memory");
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b1, 64'(i * 8), {$urandom, $urandom}, 4'b1000, 0, d, e);
    applyStimulus(1'b1, 64'(DEPTH - 16), {$urandom, $urandom}, 4'b1000, 0, d, e);
    applyStimulus(1'b1, 64'(DEPTH - 8), {$urandom, $urandom}, 4'b1000, 0, d, e);

    $display("[TB] directed load/store cases");
    applyStimulus(1'b1, 64'h10, 64'h1122334455667788, 4'b1000, 0, d, e);
    checkOutput("tp_store_rdata", d, 64'd0);
    applyStimulus(1'b0, 64'h10, 64'd0, 4'b1000, 0, d, e);
    checkOutput("tp_load8", d, 64'h1122334455667788);
    applyStimulus(1'b0, 64'h11, 64'd0, 4'b0001, 0, d, e);
    checkOutput("tp_load1", d, 64'h77);
    applyStimulus(1'b0, 64'h12, 64'd0, 4'b0010, 0, d, e);
    checkOutput("tp_load2", d, 64'h5566);
    applyStimulus(1'b0, 64'h14, 64'd0, 4'b0100, 0, d, e);
    checkOutput("tp_load4", d, 64'h11223344);
    applyStimulus(1'b1, 64'h13, 64'hFFFFFFFFFFFFFFAB, 4'b0001, 0, d, e);
    applyStimulus(1'b0, 64'h10, 64'd0, 4'b1000, 5, d, e);
    checkOutput("tp_byte_merge", d, 64'h11223344AB667788);

    $display("[TB] error cases");
    applyStimulus(1'b1, 64'h6, 64'hFFFFFFFFFFFFFFFF, 4'b0100, 0, d, e);
    checkOutput("tp_err_misalign", 64'(e), 64'd1);
    applyStimulus(1'b1, 64'h10, 64'hFFFFFFFFFFFFFFFF, 4'b0011, 0, d, e);
    checkOutput("tp_err_size", 64'(e), 64'd1);
    applyStimulus(1'b1, 64'(DEPTH - 4), 64'hFFFFFFFFFFFFFFFF, 4'b1000, 0, d, e);
    checkOutput("tp_err_bounds", 64'(e), 64'd1);
    applyStimulus(1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 4'b1000, 0, d, e);
    checkOutput("tp_err_wrap", 64'(e), 64'd1);
    checkOutput("tp_err_wrap_rdata", d, 64'd0);
    applyStimulus(1'b0, 64'h10, 64'd0, 4'b1000, 0, d, e);
    checkOutput("tp_err_nowrite", d, 64'h11223344AB667788);
    applyStimulus(1'b0, 64'h0, 64'd0, 4'b1000, 0, d, e);
    applyStimulus(1'b0, 64'(DEPTH - 8), 64'd0, 4'b1000, 0, d, e);
    checkOutput("tp_last_legal_err", 64'(e), 64'd0);

    $display("[TB] reset during WAIT");
    modelTxn(1'b1, 64'h20, 64'hDEAD, 4'b1000, e, d);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'hDEAD;
    req_size  = 4'b1000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    checkOutput("midrst_ready", 64'(req_ready), 64'd1);
    checkOutput("midrst_valid", 64'(resp_valid), 64'd0);
    checkOutput("midrst_rdata", resp_rdata, 64'd0);
    checkOutput("midrst_err", 64'(resp_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("postrst_no_resp", 64'(resp_valid), 64'd0);
    end
    applyStimulus(1'b0, 64'h20, 64'd0, 4'b1000, 0, d, e);
    checkOutput("postrst_load", d, 64'hDEAD);

    $display("[TB] random transactions");
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      w   = 1'($urandom);
      if ($urandom_range(0, 9) < 8) sz = 4'(1 << $urandom_range(0, 3));
      else sz = 4'($urandom);
      case (sz)
        4'b0001: n = 1;
        4'b0010: n = 2;
        4'b0100: n = 4;
        default: n = 8;
      endcase
      if (sel < 7) a = 64'($urandom_range(0, 255) & ~(n - 1));
      else if (sel == 7) a = 64'($urandom_range(0, 255));
      else if (sel == 8) a = 64'(DEPTH - 16 + $urandom_range(0, 16));
      else a = {$urandom, $urandom} | 64'h0000_0100_0000_0000;
      applyStimulus(w, a, {$urandom, $urandom}, sz, $urandom_range(0, 3), d, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/datamem_responder.md
Name: datamem_responder

Overview:
- Responder end of the MEM-stage data-memory interface.
- The pipelined CPU's MEM stage issues load/store requests over a valid/ready handshake. This block services them from an internal byte-addressed array.
- Read data or error status is returned after a fixed, parameterised latency.
- It replaces the single-cycle datamem so that memory latency becomes visible to the pipeline's stall logic.

Parameters:
- DEPTH_BYTES, 1024, storage size in bytes; must be a power of two and a multiple of 8.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1 to 15.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address (ALU result).
- req_wdata  input  64  store data, right-justified.
- req_size  input  4  one-hot transfer size: 0001 = 1 B, 0010 = 2 B, 0100 = 4 B, 1000 = 8 B.
- resp_valid  output  1  response present.
- resp_ready  input  1  MEM stage consumes the response.
- resp_rdata  output  64  load data, zero-extended; 0 for stores and errors.
- resp_err  output  1  request was rejected.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - Storage array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready the request is accepted and the FSM goes to WAIT with counter = LATENCY-1. If LATENCY = 1, it goes directly to RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; at 0 the FSM goes to RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable.
  - On resp_ready the FSM returns to IDLE. The next request can be accepted no earlier than the following cycle; there is no same-cycle overlap.
  - While resp_ready = 0 the FSM remains in RESP indefinitely.
- Timing: for a request accepted at edge N, resp_valid rises after edge N+LATENCY. Single outstanding transaction.
- Error check, evaluated at acceptance:
  - req_size not one-hot, OR
  - address not aligned to the transfer size, OR
  - req_addr + size > DEPTH_BYTES (computed with 65-bit arithmetic, so addresses near 2^64 do not wrap).
  - An errored request does no write; the response is resp_err = 1, resp_rdata = 0.
- Store:
  - Bytes are committed at the acceptance edge, little-endian: byte k of req_wdata goes to addr+k, for k < size.
  - Bytes outside the size are untouched.
  - Store response: resp_err = 0, resp_rdata = 0.
- Load:
  - Data is sampled at the acceptance edge, little-endian, and zero-extended to 64 bits.
  - Because a store commits at its acceptance edge, a load that follows it always sees the stored data.
- Request fields are ignored when req_ready = 0. The requester must hold its fields stable until acceptance.
- Reset mid-transaction: the pending response is discarded and the FSM returns to IDLE. A store accepted before reset remains committed.

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - enum resp_state_t {IDLE, WAIT, RESP};
  - function size_bytes(req_size) returning 0 for illegal encodings.
- Sub-module mem_lane_ctrl (combinational) produces:
  - the 8-bit byte-enable mask from req_size;
  - the misaligned flag;
  - zero-extension masking of assembled read data.
- The top-level module holds the FSM, counter, response registers and storage.

Test Plan:
- Store 0x1122334455667788, size 1000, addr 0x10; then load size 1000 from 0x10 → resp_rdata 0x1122334455667788, err 0, resp_valid exactly LATENCY cycles after each accept.
- With the above stored, load size 0001 from 0x11 → 0x77; load size 0010 from 0x12 → 0x5566; load size 0100 from 0x14 → 0x11223344.
- Store byte 0xAB (wdata 0xFFFFFFFFFFFFFFAB, size 0001) at 0x13; then load 8 B from 0x10 → 0x11223344AB667788.
- Hold resp_ready = 0 for 5 cycles → resp_valid stays 1, data stable, req_ready stays 0; raise resp_ready → IDLE, req_ready = 1 the next cycle.
- Error cases → resp_err = 1, resp_rdata = 0, memory unchanged (check with a follow-up load):
  - size 0100 at addr 0x6;
  - size 0011;
  - size 1000 at addr DEPTH_BYTES-4;
  - addr 0xFFFFFFFFFFFFFFF8.
- Assert reset = 0 mid-WAIT after an accepted store of 0xDEAD to 0x20 → outputs return to reset values immediately, no response issued; after release, load 0x20 → 0xDEAD.
